// File: rtl/display_pkg.sv
// Shared constants, commit FSM states and glyph codes
// for the 8-digit 7-segment scan controller.
package display_pkg;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned GLYPH_W = 6;
  localparam int unsigned FRAME_W = DIGITS * GLYPH_W;
  localparam int unsigned IDX_W   = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

  localparam logic [GLYPH_W-1:0] G_0     = 6'd0;
  localparam logic [GLYPH_W-1:0] G_1     = 6'd1;
  localparam logic [GLYPH_W-1:0] G_2     = 6'd2;
  localparam logic [GLYPH_W-1:0] G_3     = 6'd3;
  localparam logic [GLYPH_W-1:0] G_4     = 6'd4;
  localparam logic [GLYPH_W-1:0] G_5     = 6'd5;
  localparam logic [GLYPH_W-1:0] G_6     = 6'd6;
  localparam logic [GLYPH_W-1:0] G_7     = 6'd7;
  localparam logic [GLYPH_W-1:0] G_8     = 6'd8;
  localparam logic [GLYPH_W-1:0] G_9     = 6'd9;
  localparam logic [GLYPH_W-1:0] G_A     = 6'd10;
  localparam logic [GLYPH_W-1:0] G_B     = 6'd11;
  localparam logic [GLYPH_W-1:0] G_C     = 6'd12;
  localparam logic [GLYPH_W-1:0] G_D     = 6'd13;
  localparam logic [GLYPH_W-1:0] G_E     = 6'd14;
  localparam logic [GLYPH_W-1:0] G_F     = 6'd15;
  localparam logic [GLYPH_W-1:0] G_H     = 6'd16;
  localparam logic [GLYPH_W-1:0] G_L     = 6'd17;
  localparam logic [GLYPH_W-1:0] G_P     = 6'd18;
  localparam logic [GLYPH_W-1:0] G_DASH  = 6'd19;
  localparam logic [GLYPH_W-1:0] G_BLANK = 6'd63;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

  function automatic logic [DIGITS-1:0] digit_onehot(
    input logic [IDX_W-1:0] idx
  );
    return DIGITS'(1) << idx;
  endfunction

  function automatic logic [GLYPH_W-1:0] glyph_at(
    input logic [FRAME_W-1:0] frame,
    input logic [IDX_W-1:0]   idx
  );
    return frame[idx*GLYPH_W +: GLYPH_W];
  endfunction

endpackage

// File: rtl/display_scan_ctrl_tick.sv
// Free-running divider: tick on the last count of
// each DIV-cycle slot, guard while count < GUARD.
module scan_tick_gen #(
  parameter int unsigned DIV   = 8,
  parameter int unsigned GUARD = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick,
  output logic o_guard
);

  localparam int unsigned CW =
    (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < GUARD + 2) begin : g_bad_div
    $error("scan_tick_gen: DIV must be >= GUARD+2");
  end

  logic [CW-1:0] r_cnt;

  // slot counter, wraps DIV-1 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);

  if (GUARD == 0) begin : g_no_guard
    assign o_guard = 1'b0;
  end else begin : g_guard
    localparam logic [CW-1:0] GD = CW'(GUARD);
    assign o_guard = (r_cnt < GD);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan + double-buffered frame commit at wrap.
// Optional blink feature: DISPLAY_SCAN_BLINK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1_000,
  parameter int unsigned GUARD   = 2
`ifdef DISPLAY_SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_HZ = 2
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_wr,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic [DIGITS-1:0]  blank_mask,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]  blink_mask,
`endif
  output logic               frame_pending,
  output logic               frame_ack,
  output logic [DIGITS-1:0]  choose,
  output logic [GLYPH_W-1:0] display_data
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;

  logic w_tick;
  logic w_guard;

  scan_tick_gen #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_tick  (w_tick),
    .o_guard (w_guard)
  );

  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_shadow;
  logic [FRAME_W-1:0] r_active;
  commit_state_t      r_state;
  commit_state_t      w_state_nxt;
  logic               w_commit;
  logic               r_ack;
  logic [DIGITS-1:0]  r_choose;
  logic [GLYPH_W-1:0] r_data;
  logic [DIGITS-1:0]  w_en_mask;
  logic [DIGITS-1:0]  w_choose_nxt;

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int unsigned BLINK_DIV =
    CLK_HZ / (2 * BLINK_HZ);

  logic w_blink_tick;
  logic w_blink_guard;
  logic r_blink_off;

  scan_tick_gen #(
    .DIV   (BLINK_DIV),
    .GUARD (0)
  ) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_tick  (w_blink_tick),
    .o_guard (w_blink_guard)
  );

  // blink phase: starts on, flips every half period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_blink_off <= 1'b0;
    else if (w_blink_tick) r_blink_off <= ~r_blink_off;
  end
`endif

  // digit index advances once per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_idx <= '0;
    else if (w_tick) r_idx <= r_idx + 1'b1;
  end

  // commit FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // commit only at the 7->0 wrap so a frame never tears
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (frame_wr) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (w_tick && (r_idx == LAST_IDX)) begin
          w_commit = 1'b1;
          if (!frame_wr) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // shadow takes latest write; active takes old shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (frame_wr) r_shadow <= frame_data;
      if (w_commit) r_active <= r_shadow;
    end
  end

  // live enable mask with optional blink suppression
  always_comb begin
    w_en_mask = ~blank_mask;
`ifdef DISPLAY_SCAN_BLINK_EN
    if (r_blink_off) w_en_mask = w_en_mask & ~blink_mask;
`endif
    w_choose_nxt = '0;
    if (!w_guard)
      w_choose_nxt = digit_onehot(r_idx) & w_en_mask;
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack    <= 1'b0;
      r_choose <= '0;
      r_data   <= '0;
    end else begin
      r_ack    <= w_commit;
      r_choose <= w_choose_nxt;
      r_data   <= glyph_at(r_active, r_idx);
    end
  end

  assign frame_pending = (r_state == ST_PENDING);
  assign frame_ack     = r_ack;
  assign choose        = r_choose;
  assign display_data  = r_data;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl, DIV=8, GUARD=2.
// Optional blink checks under DISPLAY_SCAN_BLINK_EN.
module tb_display_scan_ctrl;
  import display_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_wr;
  logic [FRAME_W-1:0] frame_data;
  logic [DIGITS-1:0]  blank_mask;
  logic               frame_pending;
  logic               frame_ack;
  logic [DIGITS-1:0]  choose;
  logic [GLYPH_W-1:0] display_data;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic [DIGITS-1:0]  blink_mask;
`endif

  display_scan_ctrl #(
    .CLK_HZ  (800),
    .SCAN_HZ (100),
    .GUARD   (2)
`ifdef DISPLAY_SCAN_BLINK_EN
    ,
    .BLINK_HZ (5)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_wr      (frame_wr),
    .frame_data    (frame_data),
    .blank_mask    (blank_mask),
`ifdef DISPLAY_SCAN_BLINK_EN
    .blink_mask    (blink_mask),
`endif
    .frame_pending (frame_pending),
    .frame_ack     (frame_ack),
    .choose        (choose),
    .display_data  (display_data)
  );

  always #5 clk = ~clk;

  int n;
  int n_tests;
  int n_fail;
  int e_sw;
  logic [FRAME_W-1:0] e_old;
  logic [FRAME_W-1:0] e_new;
  logic [FRAME_W-1:0] f1, f2, fa, fb, fc, fd, fe;

  function automatic logic [FRAME_W-1:0] mk(input int base);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int i = 0; i < 8; i++)
      f[i*6 +: 6] = 6'(base + i);
    return f;
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d got=%0h exp=%0h",
               tag, n, got, exp);
    end
  endtask

  // Output after edge n reflects counter state after
  // edge n-1: slot=(n-1)%8, digit=((n-1)/8)%8.
  task automatic run(input int cycles);
    int dv;
    int ix;
    logic [7:0] ec;
    logic [FRAME_W-1:0] ef;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      n++;
      #1;
      dv = (n - 1) % 8;
      ix = ((n - 1) / 8) % 8;
      ec = (dv < 2) ? 8'h00 : ((8'h01 << ix) & ~blank_mask);
`ifdef DISPLAY_SCAN_BLINK_EN
      if (((n - 1) / 80) % 2 == 1) ec = ec & ~blink_mask;
`endif
      ef = (n > e_sw) ? e_new : e_old;
      check("choose", 64'(choose), 64'(ec));
      check("data", 64'(display_data), 64'(ef[ix*6 +: 6]));
      check("ack", 64'(frame_ack), 64'(n == e_sw));
    end
  endtask

  task automatic wr(input logic [FRAME_W-1:0] d);
    frame_wr   = 1'b1;
    frame_data = d;
    run(1);
    frame_wr   = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n       = 0;
    f1 = mk(0);
    f2 = mk(10);
    fa = mk(20);
    fb = mk(30);
    fd = mk(40);
    fc = mk(50);
    fe = mk(54);
    rst_n      = 1'b0;
    frame_wr   = 1'b0;
    frame_data = '0;
    blank_mask = 8'h00;
`ifdef DISPLAY_SCAN_BLINK_EN
    blink_mask = 8'h00;
`endif
    e_old = '0;
    e_new = '0;
    e_sw  = -1;

    #12;
    check("rst_choose", 64'(choose), 64'h0);
    check("rst_data", 64'(display_data), 64'h0);
    check("rst_pend", 64'(frame_pending), 64'h0);
    check("rst_ack", 64'(frame_ack), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    // scan order and first commit
    e_new = f1;
    e_sw  = 64;
    wr(f1);
    check("pend_f1", 64'(frame_pending), 64'h1);
    run(62);
    check("pend_f1_pre", 64'(frame_pending), 64'h1);
    run(1);
    check("pend_f1_post", 64'(frame_pending), 64'h0);
    run(72);

    // frame_wr at digit 3
    e_old = f1;
    e_new = f2;
    e_sw  = 192;
    run(18);
    wr(f2);
    check("pend_f2", 64'(frame_pending), 64'h1);
    run(36);
    check("pend_f2_pre", 64'(frame_pending), 64'h1);
    run(1);
    check("pend_f2_post", 64'(frame_pending), 64'h0);
    run(20);

    // overwrite: A then B, only B shown
    e_old = f2;
    e_new = fb;
    e_sw  = 256;
    wr(fa);
    run(5);
    wr(fb);
    check("pend_ovw", 64'(frame_pending), 64'h1);
    run(37);
    check("pend_ovw_post", 64'(frame_pending), 64'h0);
    run(70);

    // collision: write C on the commit edge of D
    e_old = fb;
    e_new = fd;
    e_sw  = 384;
    wr(fd);
    run(56);
    wr(fc);
    check("pend_coll", 64'(frame_pending), 64'h1);
    e_old = fd;
    e_new = fc;
    e_sw  = 448;
    run(64);
    check("pend_coll_post", 64'(frame_pending), 64'h0);
    run(20);

    // write on the wrap tick with nothing pending
    e_old = fc;
    e_new = fe;
    e_sw  = 576;
    run(43);
    wr(fe);
    check("pend_tick", 64'(frame_pending), 64'h1);
    run(64);
    check("pend_tick_post", 64'(frame_pending), 64'h0);
    run(10);

    // blank (and blink) masks
    e_old = fe;
    blank_mask = 8'h81;
`ifdef DISPLAY_SCAN_BLINK_EN
    blink_mask = 8'h02;
`endif
    run(200);
    blank_mask = 8'h00;
`ifdef DISPLAY_SCAN_BLINK_EN
    blink_mask = 8'h00;
`endif

    // async reset mid-scan with a frame pending
    wr(fa);
    check("pend_mid", 64'(frame_pending), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_choose", 64'(choose), 64'h0);
    check("mrst_data", 64'(display_data), 64'h0);
    check("mrst_pend", 64'(frame_pending), 64'h0);
    check("mrst_ack", 64'(frame_ack), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("mrst_hold", 64'(choose), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    e_old = '0;
    e_new = '0;
    e_sw  = -1;
    run(72);
    check("mrst_pend_end", 64'(frame_pending), 64'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
